lfsr_result_fifo: RTL and testbench

//  Downstream stage of the pseudo LFSR generator. Watches its busy/num outputs and captures num on each

---
 rtl/lfsr_result_fifo.sv | 106 ++++++++++
 tb/tb_lfsr_result_fifo.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_result_fifo.sv
// rtl/lfsr_result_fifo.sv - captures LFSR generator results on busy falling edge into a show-ahead FIFO
module lfsr_result_fifo #(
    parameter int AWIDTH = 5,
    parameter int DWIDTH = 8,
    parameter int CWIDTH = 16
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              busy_in,
    input  logic [DWIDTH-1:0] num_in,
    input  logic              cap_en,
    input  logic              flush,
    input  logic              clr_ovf,
    input  logic              rd_ready,
    output logic              rd_valid,
    output logic [DWIDTH-1:0] rd_data,
    output logic [AWIDTH:0]   count,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    output logic [CWIDTH-1:0] total_cnt
);
    localparam int DEPTH = 1 << AWIDTH;

    logic              busy_q;
    logic [AWIDTH:0]   wr_ptr;
    logic [AWIDTH:0]   rd_ptr;
    logic [DWIDTH-1:0] mem [DEPTH];

    logic push_req;
    logic pop;
    logic push;
    logic drop;
    logic do_push;
    logic do_pop;

    // Pointers carry one extra wrap bit so equal indices can be told apart as full or empty.
    assign count    = wr_ptr - rd_ptr;
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AWIDTH] != rd_ptr[AWIDTH]) &&
                      (wr_ptr[AWIDTH-1:0] == rd_ptr[AWIDTH-1:0]);
    assign rd_valid = ~empty;
    assign rd_data  = mem[rd_ptr[AWIDTH-1:0]];

    // A completed sequence is a registered-busy high while the live busy has dropped.
    assign push_req = cap_en & busy_q & ~busy_in;
    assign pop      = rd_valid & rd_ready;
    assign push     = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop & ~flush;
    assign do_push  = push & ~flush;
    assign do_pop   = pop & ~flush;

    // Track busy every cycle, independent of cap_en, so re-enabling never sees a stale edge.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            busy_q <= 1'b0;
        end else begin
            busy_q <= busy_in;
        end
    end

    // Pointer update; flush overrides any same-cycle push or pop.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage array write; contents need no reset because the pointers gate visibility.
    always_ff @(posedge wb_clk_i) begin
        if (do_push) begin
            mem[wr_ptr[AWIDTH-1:0]] <= num_in;
        end
    end

    // Sticky overflow: a drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

    // Count of accepted captures; wraps naturally.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            total_cnt <= '0;
        end else if (do_push) begin
            total_cnt <= total_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_lfsr_result_fifo.sv
// tb/tb_lfsr_result_fifo.sv - self-checking bench for lfsr_result_fifo
module tb_lfsr_result_fifo;
    localparam int AWIDTH = 5;
    localparam int DWIDTH = 8;
    localparam int CWIDTH = 16;
    localparam int DEPTH  = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              busy_in = 1'b0;
    logic [DWIDTH-1:0] num_in = '0;
    logic              cap_en = 1'b0;
    logic              flush = 1'b0;
    logic              clr_ovf = 1'b0;
    logic              rd_ready = 1'b0;
    logic              rd_valid;
    logic [DWIDTH-1:0] rd_data;
    logic [AWIDTH:0]   count;
    logic              full;
    logic              empty;
    logic              overflow;
    logic [CWIDTH-1:0] total_cnt;

    int checks = 0;
    int errors = 0;

    lfsr_result_fifo #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH), .CWIDTH(CWIDTH)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .busy_in  (busy_in),
        .num_in   (num_in),
        .cap_en   (cap_en),
        .flush    (flush),
        .clr_ovf  (clr_ovf),
        .rd_ready (rd_ready),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .overflow (overflow),
        .total_cnt(total_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of results plus sticky flag and capture total.
    logic [DWIDTH-1:0] mq[$];
    logic              m_busy_prev = 1'b0;
    logic              m_ovf = 1'b0;
    int unsigned       m_tot = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_busy_prev = 1'b0;
            m_ovf = 1'b0;
            m_tot = 0;
        end else begin
            automatic bit fell    = cap_en && m_busy_prev && !busy_in;
            automatic bit can_pop = (mq.size() > 0) && rd_ready;
            automatic bit dropped = 1'b0;
            if (flush) begin
                mq.delete();
            end else begin
                automatic bit was_full = (mq.size() == DEPTH);
                if (can_pop) void'(mq.pop_front());
                if (fell) begin
                    if (!was_full || can_pop) begin
                        mq.push_back(num_in);
                        m_tot++;
                    end else begin
                        dropped = 1'b1;
                    end
                end
            end
            if (dropped) m_ovf = 1'b1;
            else if (clr_ovf) m_ovf = 1'b0;
            m_busy_prev = busy_in;
        end
    end

    // Compare every settled cycle against the model.
    always @(negedge clk) begin
        if (!rst) begin
            check("rd_valid", rd_valid, mq.size() > 0);
            check("count", count, mq.size());
            check("full", full, mq.size() == DEPTH);
            check("empty", empty, mq.size() == 0);
            check("overflow", overflow, m_ovf);
            check("total_cnt", total_cnt, m_tot % (1 << CWIDTH));
            if (mq.size() > 0) check("rd_data", rd_data, mq[0]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        busy_in = 1'b0; flush = 1'b0; clr_ovf = 1'b0; rd_ready = 1'b0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic edge_push(input logic [DWIDTH-1:0] val);
        busy_in = 1'b1;
        tick();
        busy_in = 1'b0;
        num_in = val;
        tick();
    endtask

    task automatic pop_one();
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
    endtask

    initial begin
        cap_en = 1'b1;
        #2;
        check("reset_empty", empty, 1'b1);
        check("reset_valid", rd_valid, 1'b0);
        check("reset_count", count, 0);
        check("reset_tot", total_cnt, 0);
        do_reset();

        // 1: single capture and read
        busy_in = 1'b1;
        repeat (5) tick();
        busy_in = 1'b0;
        num_in = 8'hA5;
        tick();
        check("t1_valid", rd_valid, 1'b1);
        check("t1_data", rd_data, 8'hA5);
        check("t1_count", count, 1);
        check("t1_tot", total_cnt, 1);
        pop_one();
        check("t1_empty", empty, 1'b1);
        check("t1_count0", count, 0);

        // 2: fill, overflow, clear-vs-set, drain in order
        do_reset();
        for (int i = 0; i < 32; i++) edge_push(i[7:0]);
        check("t2_full", full, 1'b1);
        check("t2_count", count, 32);
        edge_push(8'hEE);
        check("t2_ovf", overflow, 1'b1);
        check("t2_count32", count, 32);
        check("t2_tot", total_cnt, 32);
        busy_in = 1'b1;
        tick();
        busy_in = 1'b0; num_in = 8'hEF; clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("t2_set_wins", overflow, 1'b1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("t2_clr", overflow, 1'b0);
        for (int i = 0; i < 32; i++) begin
            check("t2_drain", rd_data, i);
            pop_one();
        end
        check("t2_empty", empty, 1'b1);

        // 3: full with simultaneous push and pop
        do_reset();
        for (int i = 0; i < 32; i++) edge_push(8'(i + 100));
        busy_in = 1'b1;
        tick();
        busy_in = 1'b0; num_in = 8'h77; rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        check("t3_count", count, 32);
        check("t3_ovf", overflow, 1'b0);
        check("t3_head", rd_data, 101);
        for (int i = 0; i < 31; i++) pop_one();
        check("t3_last", rd_data, 8'h77);
        pop_one();
        check("t3_empty", empty, 1'b1);

        // 4: index wrap
        do_reset();
        for (int i = 0; i < 20; i++) edge_push(i[7:0]);
        for (int i = 0; i < 20; i++) pop_one();
        for (int i = 0; i < 20; i++) edge_push(8'(i + 40));
        check("t4_count", count, 20);
        for (int i = 0; i < 20; i++) begin
            check("t4_order", rd_data, i + 40);
            pop_one();
        end

        // 5: capture disable, re-enable, flush with same-cycle push
        do_reset();
        cap_en = 1'b0;
        edge_push(8'h11);
        check("t5_disabled", count, 0);
        cap_en = 1'b1;
        tick();
        tick();
        check("t5_no_stale", count, 0);
        check("t5_tot0", total_cnt, 0);
        for (int i = 0; i < 5; i++) edge_push(8'(i + 1));
        busy_in = 1'b1;
        tick();
        busy_in = 1'b0; num_in = 8'h99; flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t5_flush_count", count, 0);
        check("t5_flush_empty", empty, 1'b1);
        check("t5_flush_tot", total_cnt, 5);

        // 6: asynchronous reset mid-cycle
        do_reset();
        for (int i = 0; i < 33; i++) edge_push(i[7:0]);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 3; i++) edge_push(8'(i + 7));
        check("t6_pre_count", count, 3);
        check("t6_pre_ovf", overflow, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_valid", rd_valid, 1'b0);
        check("t6_count", count, 0);
        check("t6_empty", empty, 1'b1);
        check("t6_full", full, 1'b0);
        check("t6_ovf", overflow, 1'b0);
        check("t6_tot", total_cnt, 0);
        tick();
        rst = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
